// File: rtl/joystick_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// joystick_cmd_scheduler
//
// Turns two players' debounced joystick levels and fire pulses into a single
// valid/ready command stream for the game engine.
//   * Direction levels become auto-repeating move events: one event on press,
//     one after INIT_DELAY cycles, then one every REPEAT_PERIOD cycles.
//   * Fire pulses become fire events, rate limited by a per-player cooldown
//     that starts when the fire command is granted.
//   * Each player has a one-deep move slot and a one-deep fire slot. Fire
//     beats move within a player; players are arbitrated round-robin.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous reset, active high
//   i_p0_dir      player 0 levels {up,down,left,right}
//   i_p0_fire     player 0 fire, one-cycle pulse
//   i_p1_dir      player 1 levels {up,down,left,right}
//   i_p1_fire     player 1 fire, one-cycle pulse
//   i_cmd_ready   engine accepts the current command
//   o_cmd_valid   command available
//   o_cmd_player  0 = player 0, 1 = player 1
//   o_cmd_code    1=up 2=down 3=left 4=right 5=fire
//   o_drop        one-cycle pulse when any fire pulse was discarded
// ---------------------------------------------------------------------------
module joystick_cmd_scheduler #(
    parameter int CNT_W         = 24,
    parameter int INIT_DELAY    = 20,
    parameter int REPEAT_PERIOD = 5,
    parameter int FIRE_COOLDOWN = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_p0_dir,
    input  logic       i_p0_fire,
    input  logic [3:0] i_p1_dir,
    input  logic       i_p1_fire,
    input  logic       i_cmd_ready,
    output logic       o_cmd_valid,
    output logic       o_cmd_player,
    output logic [2:0] o_cmd_code,
    output logic       o_drop
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_INIT = 2'd1,
        REPEAT    = 2'd2
    } move_state_t;

    localparam logic [CNT_W-1:0] INIT_LOAD   = CNT_W'(INIT_DELAY - 1);
    localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(FIRE_COOLDOWN);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [2:0]       CODE_NONE   = 3'd0;
    localparam logic [2:0]       CODE_FIRE   = 3'd5;

    // Highest-priority asserted direction: up > down > left > right.
    function automatic logic [2:0] dir_sel(input logic [3:0] d);
        logic [2:0] code;
        code = CODE_NONE;
        if (d[3])      code = 3'd1;
        else if (d[2]) code = 3'd2;
        else if (d[1]) code = 3'd3;
        else if (d[0]) code = 3'd4;
        return code;
    endfunction

    // Player-indexed views of the inputs.
    logic [1:0][3:0] dir;
    logic [1:0]      fire;

    assign dir  = {i_p1_dir, i_p0_dir};
    assign fire = {i_p1_fire, i_p0_fire};

    // Per-player state.
    move_state_t           move_state [2];
    logic [1:0][2:0]       cur_code;     // direction the FSM is tracking
    logic [1:0][2:0]       move_code;    // code held in the move slot
    logic [1:0][CNT_W-1:0] move_cnt;
    logic [1:0][CNT_W-1:0] fire_cnt;     // fire cooldown
    logic [1:0]            move_pend;
    logic [1:0]            fire_pend;
    logic                  last_grant;

    // Combinational decode / arbitration.
    logic [1:0][2:0] sel_code;
    logic [1:0]      cand;
    logic [1:0]      fire_acc;
    logic [1:0]      fire_drop;
    logic [1:0]      gnt_move;
    logic [1:0]      gnt_fire;
    logic            gnt_player;
    logic            load;
    logic [2:0]      gnt_code;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            sel_code[p]  = dir_sel(dir[p]);
            cand[p]      = fire_pend[p] | move_pend[p];
            // A pulse while the slot is full covers the same-cycle-as-grant
            // case too: a grant implies the slot is still full this cycle.
            fire_acc[p]  = fire[p] & ~fire_pend[p] & (fire_cnt[p] == '0);
            fire_drop[p] = fire[p] & ~fire_acc[p];
        end

        // With both players waiting, the one not served last goes first.
        gnt_player = (cand[0] & cand[1]) ? ~last_grant : cand[1];
        load       = (~o_cmd_valid | i_cmd_ready) & (|cand);
        gnt_code   = fire_pend[gnt_player] ? CODE_FIRE : move_code[gnt_player];

        gnt_fire             = '0;
        gnt_move             = '0;
        gnt_fire[gnt_player] = load & fire_pend[gnt_player];
        gnt_move[gnt_player] = load & ~fire_pend[gnt_player];
    end

    // Move FSMs. The grant clear comes first so that an event landing in the
    // same cycle re-arms the slot (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                move_state[p] <= IDLE;
                cur_code[p]   <= CODE_NONE;
                move_code[p]  <= CODE_NONE;
                move_cnt[p]   <= '0;
                move_pend[p]  <= 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (gnt_move[p])
                    move_pend[p] <= 1'b0;

                if (sel_code[p] == CODE_NONE) begin
                    // Release drops any move not yet handed to the engine.
                    move_state[p] <= IDLE;
                    cur_code[p]   <= CODE_NONE;
                    move_cnt[p]   <= '0;
                    move_pend[p]  <= 1'b0;
                end else if (move_state[p] == IDLE || sel_code[p] != cur_code[p]) begin
                    // New press, or a switch to another direction.
                    move_state[p] <= WAIT_INIT;
                    cur_code[p]   <= sel_code[p];
                    move_code[p]  <= sel_code[p];
                    move_cnt[p]   <= INIT_LOAD;
                    move_pend[p]  <= 1'b1;
                end else if (move_cnt[p] != '0) begin
                    move_cnt[p] <= move_cnt[p] - CNT_ONE;
                end else begin
                    // Initial delay or repeat period expired.
                    move_state[p] <= REPEAT;
                    move_code[p]  <= cur_code[p];
                    move_cnt[p]   <= REPEAT_LOAD;
                    move_pend[p]  <= 1'b1;
                end
            end
        end
    end

    // Fire slots and cooldowns.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                fire_pend[p] <= 1'b0;
                fire_cnt[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (fire_acc[p])
                    fire_pend[p] <= 1'b1;
                else if (gnt_fire[p])
                    fire_pend[p] <= 1'b0;

                if (gnt_fire[p])
                    fire_cnt[p] <= COOL_LOAD;
                else if (fire_cnt[p] != '0)
                    fire_cnt[p] <= fire_cnt[p] - CNT_ONE;
            end
        end
    end

    // Output register and round-robin pointer. player/code only change on a
    // load, so they stay stable through a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_cmd_valid  <= 1'b0;
            o_cmd_player <= 1'b0;
            o_cmd_code   <= CODE_NONE;
            o_drop       <= 1'b0;
            last_grant   <= 1'b1;
        end else begin
            o_drop <= |fire_drop;
            if (load) begin
                o_cmd_valid  <= 1'b1;
                o_cmd_player <= gnt_player;
                o_cmd_code   <= gnt_code;
                last_grant   <= gnt_player;
            end else if (i_cmd_ready) begin
                o_cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_joystick_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// Bench for joystick_cmd_scheduler. A cycle-level model built from the
// event rules (press age, cooldown age, one-deep slots, round-robin) is
// stepped alongside the DUT and compared on every cycle. Directed scenarios
// add literal expectations at known cycles.
// ---------------------------------------------------------------------------
module tb_joystick_cmd_scheduler;

    localparam int INIT_DELAY    = 20;
    localparam int REPEAT_PERIOD = 5;
    localparam int FIRE_COOLDOWN = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] p0_dir = 4'd0, p1_dir = 4'd0;
    logic       p0_fire = 1'b0, p1_fire = 1'b0;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid, cmd_player, drop;
    logic [2:0] cmd_code;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    joystick_cmd_scheduler #(
        .CNT_W(24), .INIT_DELAY(INIT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD), .FIRE_COOLDOWN(FIRE_COOLDOWN)
    ) dut (
        .clk(clk), .rst(rst),
        .i_p0_dir(p0_dir), .i_p0_fire(p0_fire),
        .i_p1_dir(p1_dir), .i_p1_fire(p1_fire),
        .i_cmd_ready(cmd_ready),
        .o_cmd_valid(cmd_valid), .o_cmd_player(cmd_player),
        .o_cmd_code(cmd_code), .o_drop(drop)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit         m_valid, m_player, m_drop, m_last;
    logic [2:0] m_code;
    bit         m_mp [2];
    bit         m_fp [2];
    logic [2:0] m_mc [2];
    logic [2:0] m_held [2];
    int         m_age [2];     // cycles since the held direction was pressed
    int         m_lastg [2];   // model time of the last fire grant
    int         m_t = 0;

    function automatic logic [2:0] pick_dir(input logic [3:0] d);
        for (int c = 1; c <= 4; c++)
            if (d[4-c]) return 3'(c);
        return 3'd0;
    endfunction

    task automatic model_step();
        logic [3:0] d [2];
        bit         f [2];
        bit         cand [2];
        bit         acc [2];
        bit         nmp [2];
        bit         nfp [2];
        bit         ld;
        int         g;
        logic [2:0] sel;
        d[0] = p0_dir;  d[1] = p1_dir;
        f[0] = p0_fire; f[1] = p1_fire;
        m_t++;
        if (rst) begin
            m_valid = 0; m_player = 0; m_code = 3'd0; m_drop = 0; m_last = 1;
            for (int p = 0; p < 2; p++) begin
                m_mp[p] = 0; m_fp[p] = 0; m_mc[p] = 3'd0; m_held[p] = 3'd0;
                m_age[p] = 0; m_lastg[p] = -100000;
            end
            return;
        end
        for (int p = 0; p < 2; p++) begin
            cand[p] = m_fp[p] || m_mp[p];
            nmp[p]  = m_mp[p];
            nfp[p]  = m_fp[p];
            acc[p]  = f[p] && !m_fp[p] && (m_t - m_lastg[p] > FIRE_COOLDOWN);
        end
        m_drop = (f[0] && !acc[0]) || (f[1] && !acc[1]);
        ld = (!m_valid || cmd_ready) && (cand[0] || cand[1]);
        if (cand[0] && cand[1]) g = m_last ? 0 : 1;
        else                    g = cand[1] ? 1 : 0;
        if (ld) begin
            m_valid  = 1;
            m_player = (g == 1);
            m_last   = (g == 1);
            if (m_fp[g]) begin
                m_code = 3'd5; nfp[g] = 0; m_lastg[g] = m_t;
            end else begin
                m_code = m_mc[g]; nmp[g] = 0;
            end
        end else if (cmd_ready) begin
            m_valid = 0;
        end
        for (int p = 0; p < 2; p++) begin
            sel = pick_dir(d[p]);
            if (sel == 3'd0) begin
                nmp[p] = 0; m_held[p] = 3'd0;
            end else begin
                if (sel != m_held[p]) m_age[p] = 0;
                else                  m_age[p] = m_age[p] + 1;
                m_held[p] = sel;
                if ((m_age[p] == 0) ||
                    ((m_age[p] >= INIT_DELAY) && ((m_age[p] - INIT_DELAY) % REPEAT_PERIOD == 0))) begin
                    nmp[p] = 1; m_mc[p] = sel;
                end
            end
            if (acc[p]) nfp[p] = 1;
            m_mp[p] = nmp[p];
            m_fp[p] = nfp[p];
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // One clock: model consumes the inputs, DUT clocks, outputs compared.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("model_valid",  {7'd0, cmd_valid},  {7'd0, m_valid});
        chk("model_drop",   {7'd0, drop},       {7'd0, m_drop});
        chk("model_player", {7'd0, cmd_player}, {7'd0, m_player});
        chk("model_code",   {5'd0, cmd_code},   {5'd0, m_code});
    endtask

    task automatic do_reset();
        rst = 1; p0_dir = 0; p1_dir = 0; p0_fire = 0; p1_fire = 0; cmd_ready = 1;
        tick();
        tick();
        rst = 0;
        cyc = 0;
        chk("reset_valid",  {7'd0, cmd_valid},  8'd0);
        chk("reset_player", {7'd0, cmd_player}, 8'd0);
        chk("reset_code",   {5'd0, cmd_code},   8'd0);
        chk("reset_drop",   {7'd0, drop},       8'd0);
    endtask

    int  n_grants;
    bit  prev_player;
    bit  exp_v;

    initial begin
        // 1: fire latency, drop during cooldown, re-fire after cooldown.
        do_reset();
        for (int c = 0; c < 26; c++) begin
            p0_fire = (c == 5 || c == 9 || c == 17);
            tick();
            if (cyc == 7) begin
                chk("s1_fire_valid", {7'd0, cmd_valid}, 8'd1);
                chk("s1_fire_code",  {5'd0, cmd_code},  8'd5);
                chk("s1_fire_player", {7'd0, cmd_player}, 8'd0);
            end
            if (cyc == 8)  chk("s1_one_cycle", {7'd0, cmd_valid}, 8'd0);
            if (cyc == 10) chk("s1_drop",      {7'd0, drop},      8'd1);
            if (cyc == 11) chk("s1_drop_end",  {7'd0, drop},      8'd0);
            if (cyc == 19) begin
                chk("s1_refire_valid", {7'd0, cmd_valid}, 8'd1);
                chk("s1_refire_code",  {5'd0, cmd_code},  8'd5);
            end
        end
        p0_fire = 0;

        // 2: held left on player 1, auto-repeat schedule.
        do_reset();
        for (int c = 0; c < 56; c++) begin
            p1_dir = (c <= 40) ? 4'b0010 : 4'b0000;
            tick();
            exp_v = (cyc == 2 || cyc == 22 || cyc == 27 || cyc == 32 || cyc == 37 || cyc == 42);
            chk("s2_repeat_valid", {7'd0, cmd_valid}, {7'd0, exp_v});
            if (exp_v) begin
                chk("s2_repeat_code",   {5'd0, cmd_code},   8'd3);
                chk("s2_repeat_player", {7'd0, cmd_player}, 8'd1);
            end
        end
        p1_dir = 0;

        // 3: simultaneous fire pairs, strict alternation.
        do_reset();
        n_grants = 0;
        prev_player = 0;
        for (int c = 0; c < 150; c++) begin
            p0_fire = (c % 15 == 0) && (c < 150);
            p1_fire = p0_fire;
            tick();
            if (cmd_valid) begin
                n_grants++;
                if (n_grants == 1) chk("s3_first_p0", {7'd0, cmd_player}, 8'd0);
                else               chk("s3_alternate", {7'd0, cmd_player}, {7'd0, !prev_player});
                prev_player = cmd_player;
            end
        end
        p0_fire = 0; p1_fire = 0;
        chk("s3_grant_count", 8'(n_grants), 8'd20);

        // 4: stalled engine while player 0 holds up.
        do_reset();
        for (int c = 0; c < 40; c++) begin
            p0_dir = 4'b1000;
            cmd_ready = (c >= 30);
            tick();
            if (cyc >= 2 && cyc <= 30) begin
                chk("s4_stall_valid", {7'd0, cmd_valid}, 8'd1);
                chk("s4_stall_code",  {5'd0, cmd_code},  8'd1);
            end
            if (cyc == 31) chk("s4_release_valid", {7'd0, cmd_valid}, 8'd1);
            if (cyc == 32) chk("s4_set_wins",      {7'd0, cmd_valid}, 8'd1);
            if (cyc == 33) chk("s4_empty",         {7'd0, cmd_valid}, 8'd0);
        end
        p0_dir = 0;

        // 5: up+left gives up; dropping up gives a fresh left press.
        do_reset();
        for (int c = 0; c < 36; c++) begin
            p0_dir = (c < 10) ? 4'b1010 : 4'b0010;
            tick();
            if (cyc == 2)  chk("s5_up_code",    {5'd0, cmd_code},  8'd1);
            if (cyc == 12) begin
                chk("s5_left_valid", {7'd0, cmd_valid}, 8'd1);
                chk("s5_left_code",  {5'd0, cmd_code},  8'd3);
            end
            if (cyc == 22) chk("s5_no_repeat",  {7'd0, cmd_valid}, 8'd0);
            if (cyc == 32) chk("s5_left_init",  {5'd0, cmd_code},  8'd3);
        end
        p0_dir = 0;

        // 6: reset while a command is stalled.
        do_reset();
        for (int c = 0; c < 15; c++) begin
            cmd_ready = 0;
            p0_fire = (c == 0);
            p1_dir = 4'b0100;
            rst = (c == 5);
            tick();
            if (cyc == 3) chk("s6_stalled", {7'd0, cmd_valid}, 8'd1);
            if (cyc == 6) begin
                chk("s6_rst_valid",  {7'd0, cmd_valid},  8'd0);
                chk("s6_rst_player", {7'd0, cmd_player}, 8'd0);
                chk("s6_rst_code",   {5'd0, cmd_code},   8'd0);
                chk("s6_rst_drop",   {7'd0, drop},       8'd0);
            end
            if (cyc == 8) begin
                chk("s6_after_valid",  {7'd0, cmd_valid},  8'd1);
                chk("s6_after_player", {7'd0, cmd_player}, 8'd1);
                chk("s6_after_code",   {5'd0, cmd_code},   8'd2);
            end
        end
        rst = 0; p0_fire = 0; p1_dir = 0; cmd_ready = 1;

        // 7: random traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            cmd_ready = ($urandom % 4) != 0;
            if ($urandom % 20 == 0) p0_dir = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom);
            if ($urandom % 20 == 0) p1_dir = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom);
            p0_fire = ($urandom % 6) == 0;
            p1_fire = ($urandom % 6) == 0;
            rst = ($urandom % 700) == 0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
